multi_port_issue_queue: RTL and testbench
=========================================

// Module: multi_port_issue_queue
// PURPOSE
// Parametrised in-order issue queue between decode and issue; successor of the fixed 4-in/2-out queue.
// Accepts up to PUSH_W decoded elements per cycle and presents the oldest POP_W entries to issue.
// Issue consumes a variable count per cycle. Adds flush priority, overflow/underflow detection,
// zero-gated invalid head lanes, and generic element width/depth/port counts.
// PARAMETERS
// ELEM_W  64  width in bits of one queue element (packed ISSUE_QUEUE_ELEMENT)
// DEPTH   16  number of entries; power of two, DEPTH >= PUSH_W + POP_W
// PUSH_W  4   maximum elements pushed per cycle
// POP_W   2   maximum elements popped per cycle
// PORTS
// clk           in   1                   clock; all state updates on rising edge
// rst           in   1                   synchronous, active-high reset
// flush         in   1                   discard all entries (branch mispredict redirect)
// push_num      in   $clog2(PUSH_W+1)    number of valid lanes in push_data, lanes 0..push_num-1
// push_data     in   PUSH_W*ELEM_W       lane i = bits [i*ELEM_W +: ELEM_W]; lane 0 oldest
// free_slots    out  $clog2(PUSH_W+1)    min(DEPTH-count, PUSH_W); decode stalls when < its need
// pop_num       in   $clog2(POP_W+1)     number of head entries consumed this cycle
// head_data     out  POP_W*ELEM_W        oldest entries; lane 0 = head
// head_valid    out  $clog2(POP_W+1)     min(count, POP_W)
// count         out  $clog2(DEPTH+1)     current occupancy
// overflow_err  out  1                   1-cycle pulse: previous push rejected
// underflow_err out  1                   1-cycle pulse: previous pop clamped
// BEHAVIOUR
// - State: storage[DEPTH], head_ptr and tail_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count reg.
// - Reset (rst=1 at edge): head_ptr=tail_ptr=0, count=0, overflow_err=underflow_err=0.
//   Storage is not cleared. Reset dominates flush, push and pop.
// - Flush (flush=1, rst=0): same register effect as reset. Dominates push and pop in that cycle.
// - head_data, head_valid, free_slots are combinational from registered state only.
//   No dependency on push_* or pop_num.
// - head_data lane i = storage[(head_ptr+i) mod DEPTH] if i < head_valid, else all zeros.
// - Push: accepted iff push_num <= free_slots computed from current count (no credit for a same-cycle pop).
//   Lane i writes storage[(tail_ptr+i) mod DEPTH]; tail_ptr += push_num.
// - Rejected push: push_num > free_slots. Nothing is written and tail_ptr is unchanged (no partial push).
//   overflow_err=1 on the next cycle.
// - Pop: effective pop = min(pop_num, head_valid); head_ptr += effective pop.
//   If pop_num > head_valid, underflow_err=1 on the next cycle.
// - Simultaneous push and pop: both apply in the same edge.
//   count_next = count + accepted_push - effective_pop. Never exceeds DEPTH, never negative.
// - Latency: a pushed entry is visible on head_data in the cycle after the push edge (no fall-through).
//   A popped entry disappears in the cycle after the pop edge.
// - Ordering: strict FIFO across lanes and cycles, including across pointer wrap.
// - Error pulses last exactly one cycle unless the condition repeats. They are cleared by rst or flush.
// - push_num=0 and pop_num=0 hold all state.
// TESTING
// 1. After reset: push 4 elems A..D -> next cycle count=4, head_valid=2, head_data={B,A}, free_slots=4.
// 2. Fill to 16 via 4x push_num=4 -> free_slots=0. Push 1 more -> rejected, overflow_err pulses once,
//    count stays 16.
// 3. Wrap: push/pop 2 per cycle for 20 cycles on streaming data -> output order matches input order,
//    pointers wrap past 15, count is constant.
// 4. count=1, pop_num=2 -> count=0, underflow_err=1 next cycle, head_valid=0, head_data all zeros.
// 5. count=10, push 4 + pop 2 + flush in the same cycle -> next cycle count=0, free_slots=4, head_valid=0.
// 6. Reset mid-operation with count=7 and an active push -> next cycle count=0, both errors 0.
//    A following push of 3 is visible correctly.

Source files
------------

// File: rtl/multi_port_issue_queue.sv
// In-order issue queue: accepts up to PUSH_W elements per cycle, presents the oldest POP_W
// entries to issue, and reports rejected pushes and clamped pops as one-cycle error pulses.
module multi_port_issue_queue #(
    parameter int ELEM_W = 64,
    parameter int DEPTH  = 16,
    parameter int PUSH_W = 4,
    parameter int POP_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [$clog2(PUSH_W+1)-1:0]  push_num,
    input  logic [PUSH_W*ELEM_W-1:0]     push_data,
    output logic [$clog2(PUSH_W+1)-1:0]  free_slots,
    input  logic [$clog2(POP_W+1)-1:0]   pop_num,
    output logic [POP_W*ELEM_W-1:0]      head_data,
    output logic [$clog2(POP_W+1)-1:0]   head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PN_W  = $clog2(PUSH_W + 1);
    localparam int PO_W  = $clog2(POP_W + 1);

    logic [ELEM_W-1:0] r_storage [DEPTH];
    logic [PTR_W-1:0]  r_head_ptr;
    logic [PTR_W-1:0]  r_tail_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow_err;
    logic              r_underflow_err;

    logic [CNT_W-1:0]  w_space;
    logic              w_push_ok;
    logic              w_pop_over;
    logic [PN_W-1:0]   w_push_acc;
    logic [PO_W-1:0]   w_pop_eff;

    // Status outputs depend on registered state only, so decode/issue see no same-cycle paths.
    assign w_space    = CNT_W'(DEPTH) - r_count;
    assign free_slots = (w_space > CNT_W'(PUSH_W)) ? PN_W'(PUSH_W) : PN_W'(w_space);
    assign head_valid = (r_count > CNT_W'(POP_W)) ? PO_W'(POP_W) : PO_W'(r_count);

    assign w_push_ok  = (push_num <= free_slots);
    assign w_push_acc = w_push_ok ? push_num : '0;
    assign w_pop_over = (pop_num > head_valid);
    assign w_pop_eff  = w_pop_over ? head_valid : pop_num;

    assign count         = r_count;
    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;

    always_comb begin
        head_data = '0;
        for (int i = 0; i < POP_W; i++) begin
            if (PO_W'(i) < head_valid) begin
                head_data[i*ELEM_W +: ELEM_W] = r_storage[r_head_ptr + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head_ptr      <= '0;
            r_tail_ptr      <= '0;
            r_count         <= '0;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_head_ptr      <= r_head_ptr + PTR_W'(w_pop_eff);
            r_tail_ptr      <= r_tail_ptr + PTR_W'(w_push_acc);
            r_count         <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_eff);
            r_overflow_err  <= !w_push_ok;
            r_underflow_err <= w_pop_over;
        end
    end

    // NOTE: storage has no reset; entries outside [head, head+count) are never observed.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < PUSH_W; i++) begin
                if (PN_W'(i) < w_push_acc) begin
                    r_storage[r_tail_ptr + PTR_W'(i)] <= push_data[i*ELEM_W +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_port_issue_queue.sv
// Self-checking bench for multi_port_issue_queue: a vector table of per-cycle expectations plus
// a queue scoreboard holding every accepted element in issue order.
module tb_multi_port_issue_queue;

    localparam int ELEM_W = 64;
    localparam int DEPTH  = 16;
    localparam int PUSH_W = 4;
    localparam int POP_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     flush = 1'b0;
    logic [2:0]               push_num = '0;
    logic [PUSH_W*ELEM_W-1:0] push_data = '0;
    logic [2:0]               free_slots;
    logic [1:0]               pop_num = '0;
    logic [POP_W*ELEM_W-1:0]  head_data;
    logic [1:0]               head_valid;
    logic [4:0]               count;
    logic                     overflow_err;
    logic                     underflow_err;

    int n_checks = 0;
    int n_errors = 0;
    int seq      = 0;
    logic [63:0] sb_q[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    typedef struct {
        logic f;
        int   pn;
        int   pp;
        int   e_cnt;
        int   e_hv;
        int   e_free;
        logic e_ovf;
        logic e_udf;
    } vec_t;

    vec_t vecs[16];

    multi_port_issue_queue #(
        .ELEM_W(ELEM_W), .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_num(push_num), .push_data(push_data), .free_slots(free_slots),
        .pop_num(pop_num), .head_data(head_data), .head_valid(head_valid),
        .count(count), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle, compares popped lanes against the scoreboard, then advances the model.
    task automatic drive_cycle(input logic r, input logic f, input int pn, input int pp);
        logic [63:0] lane [PUSH_W];
        int size, free_m, hv_m, eff;
        size   = sb_q.size();
        free_m = (DEPTH - size > PUSH_W) ? PUSH_W : DEPTH - size;
        hv_m   = (size > POP_W) ? POP_W : size;
        eff    = (pp > hv_m) ? hv_m : pp;
        for (int i = 0; i < PUSH_W; i++) begin
            lane[i] = 64'hC0DE_0000_0000_0000 + 64'(seq + i);
            push_data[i*ELEM_W +: ELEM_W] = lane[i];
        end
        rst      = r;
        flush    = f;
        push_num = 3'(pn);
        pop_num  = 2'(pp);
        if (!r && !f) begin
            for (int j = 0; j < eff; j++) begin
                check($sformatf("pop_data[%0d]", j), head_data[j*ELEM_W +: ELEM_W], sb_q[j]);
            end
        end
        @(posedge clk);
        #1;
        if (r || f) begin
            sb_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            for (int j = 0; j < eff; j++) void'(sb_q.pop_front());
            m_ovf = (pn > free_m);
            m_udf = (pp > hv_m);
            if (pn <= free_m) begin
                for (int i = 0; i < pn; i++) sb_q.push_back(lane[i]);
            end
        end
        seq      = seq + pn;
        rst      = 1'b0;
        flush    = 1'b0;
        push_num = '0;
        pop_num  = '0;
    endtask

    task automatic check_model(input string tag);
        int size;
        size = sb_q.size();
        check({tag, ".count"}, 64'(count), 64'(size));
        check({tag, ".head_valid"}, 64'(head_valid), 64'((size > POP_W) ? POP_W : size));
        check({tag, ".free_slots"}, 64'(free_slots),
              64'((DEPTH - size > PUSH_W) ? PUSH_W : DEPTH - size));
        check({tag, ".overflow_err"}, 64'(overflow_err), 64'(m_ovf));
        check({tag, ".underflow_err"}, 64'(underflow_err), 64'(m_udf));
        for (int i = 0; i < POP_W; i++) begin
            check($sformatf("%s.head_data[%0d]", tag, i), head_data[i*ELEM_W +: ELEM_W],
                  (i < size) ? sb_q[i] : 64'h0);
        end
    endtask

    initial begin
        //          f  pn pp  cnt hv free ovf udf
        vecs[0]  = '{0, 4, 0,  4, 2, 4, 0, 0};
        vecs[1]  = '{0, 4, 0,  8, 2, 4, 0, 0};
        vecs[2]  = '{0, 4, 0, 12, 2, 4, 0, 0};
        vecs[3]  = '{0, 4, 0, 16, 2, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, 16, 2, 0, 1, 0};
        vecs[5]  = '{0, 0, 0, 16, 2, 0, 0, 0};
        vecs[6]  = '{0, 0, 2, 14, 2, 2, 0, 0};
        vecs[7]  = '{0, 3, 0, 14, 2, 2, 1, 0};
        vecs[8]  = '{0, 2, 2, 14, 2, 2, 0, 0};
        vecs[9]  = '{0, 0, 2, 12, 2, 4, 0, 0};
        vecs[10] = '{1, 4, 2,  0, 0, 4, 0, 0};
        vecs[11] = '{0, 1, 0,  1, 1, 4, 0, 0};
        vecs[12] = '{0, 0, 2,  0, 0, 4, 0, 1};
        vecs[13] = '{0, 0, 0,  0, 0, 4, 0, 0};
        vecs[14] = '{0, 0, 1,  0, 0, 4, 0, 1};
        vecs[15] = '{1, 0, 0,  0, 0, 4, 0, 0};

        drive_cycle(1'b1, 1'b0, 0, 0);
        check_model("reset");

        for (int k = 0; k < 16; k++) begin
            drive_cycle(1'b0, vecs[k].f, vecs[k].pn, vecs[k].pp);
            check($sformatf("vec%0d.count", k), 64'(count), 64'(vecs[k].e_cnt));
            check($sformatf("vec%0d.head_valid", k), 64'(head_valid), 64'(vecs[k].e_hv));
            check($sformatf("vec%0d.free_slots", k), 64'(free_slots), 64'(vecs[k].e_free));
            check($sformatf("vec%0d.overflow_err", k), 64'(overflow_err), 64'(vecs[k].e_ovf));
            check($sformatf("vec%0d.underflow_err", k), 64'(underflow_err), 64'(vecs[k].e_udf));
            check_model($sformatf("vec%0d", k));
        end

        // Streaming push2/pop2 for 20 cycles: occupancy constant, pointers wrap several times.
        drive_cycle(1'b0, 1'b0, 4, 0);
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b0, 1'b0, 2, 2);
            check("wrap.count", 64'(count), 64'd4);
            check_model("wrap");
        end

        // Flush dominates simultaneous push and pop at count 10.
        drive_cycle(1'b0, 1'b1, 0, 0);
        drive_cycle(1'b0, 1'b0, 4, 0);
        drive_cycle(1'b0, 1'b0, 4, 0);
        drive_cycle(1'b0, 1'b0, 2, 0);
        check("pre_flush.count", 64'(count), 64'd10);
        drive_cycle(1'b0, 1'b1, 4, 2);
        check("flush.count", 64'(count), 64'd0);
        check("flush.free_slots", 64'(free_slots), 64'd4);
        check("flush.head_valid", 64'(head_valid), 64'd0);
        check("flush.head_data", head_data[63:0] | head_data[127:64], 64'h0);

        // Reset with count 7 and an active push, then a push of 3 flows through in order.
        drive_cycle(1'b0, 1'b0, 4, 0);
        drive_cycle(1'b0, 1'b0, 3, 0);
        check("pre_reset.count", 64'(count), 64'd7);
        drive_cycle(1'b1, 1'b0, 4, 2);
        check("reset_mid.count", 64'(count), 64'd0);
        check("reset_mid.overflow_err", 64'(overflow_err), 64'd0);
        check("reset_mid.underflow_err", 64'(underflow_err), 64'd0);
        drive_cycle(1'b0, 1'b0, 3, 0);
        check("post_reset.count", 64'(count), 64'd3);
        check_model("post_reset");
        drive_cycle(1'b0, 1'b0, 0, 2);
        check_model("post_reset_pop");
        drive_cycle(1'b0, 1'b0, 0, 2);
        check("drain.underflow_err", 64'(underflow_err), 64'd1);
        check_model("drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
